rob_buffer: RTL and testbench

In-order reorder buffer that allocates a ticket per instruction at decode and absorbs out-of-order results from two writeback ports (port 0: single-cycle ALU; port 1: output of the multi-stage F pipeline). It commits completed entries in program order to the register file. It also answers decode's operand lookups: the youngest in-flight producer ticket per source register, plus its value if already written back. Those tickets feed the F pipeline's per-stage bypass comparators.

---
 rtl/rob_buffer_pkg.sv | 10 +
 rtl/rob_lookup.sv | 44 ++++
 rtl/rob_buffer.sv | 164 ++++++++++++++++
 tb/tb_rob_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_buffer_pkg.sv
// Shared widths and sizing defaults for the reorder buffer and its lookup search.
package rob_buffer_pkg;

  localparam int unsigned ROB_ENTRIES  = 8;
  localparam int unsigned ROB_TICKET_W = 3;
  localparam int unsigned ROB_DATA_W   = 16;
  localparam int unsigned ROB_REG_W    = 3;
  localparam int unsigned ROB_PC_W     = 16;

endpackage

// File: rtl/rob_lookup.sv
// Youngest-producer search: walks backwards from tail and reports the first
// valid, register-writing entry whose destination matches addr.
module rob_lookup
  import rob_buffer_pkg::*;
#(
  parameter int unsigned ENTRIES  = ROB_ENTRIES,
  parameter int unsigned TICKET_W = ROB_TICKET_W,
  parameter int unsigned DATA_W   = ROB_DATA_W,
  parameter int unsigned REG_W    = ROB_REG_W
) (
  input  logic [ENTRIES-1:0]             valid,
  input  logic [ENTRIES-1:0]             we,
  input  logic [ENTRIES-1:0]             done,
  input  logic [ENTRIES-1:0][REG_W-1:0]  dest,
  input  logic [ENTRIES-1:0][DATA_W-1:0] data,
  input  logic [TICKET_W-1:0]            tail,
  input  logic [REG_W-1:0]               addr,
  output logic                           pending,
  output logic [TICKET_W-1:0]            ticket,
  output logic                           ready,
  output logic [DATA_W-1:0]              result
);

  logic [TICKET_W-1:0] idx;

  // Offsets 1..ENTRIES below tail visit entries youngest-first in wrap order.
  always_comb begin
    pending = 1'b0;
    ticket  = '0;
    ready   = 1'b0;
    result  = '0;
    idx     = '0;
    for (int unsigned k = 1; k <= ENTRIES; k++) begin
      idx = tail - TICKET_W'(k);
      if (!pending && valid[idx] && we[idx] && (dest[idx] == addr)) begin
        pending = 1'b1;
        ticket  = idx;
        ready   = done[idx];
        result  = done[idx] ? data[idx] : '0;
      end
    end
  end

endmodule

// File: rtl/rob_buffer.sv
// In-order reorder buffer: ticket allocation at decode, two out-of-order
// writeback ports, single in-order commit per cycle, and operand lookups.
module rob_buffer
  import rob_buffer_pkg::*;
#(
  parameter int unsigned ENTRIES  = ROB_ENTRIES,
  parameter int unsigned TICKET_W = ROB_TICKET_W,
  parameter int unsigned DATA_W   = ROB_DATA_W,
  parameter int unsigned REG_W    = ROB_REG_W,
  parameter int unsigned PC_W     = ROB_PC_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                alloc_valid,
  input  logic [REG_W-1:0]    alloc_dest,
  input  logic                alloc_we,
  input  logic [PC_W-1:0]     alloc_pc,
  output logic                alloc_ready,
  output logic [TICKET_W-1:0] tail_rob,
  input  logic                wb0_valid,
  input  logic [TICKET_W-1:0] wb0_ticket,
  input  logic [DATA_W-1:0]   wb0_data,
  input  logic                wb1_valid,
  input  logic [TICKET_W-1:0] wb1_ticket,
  input  logic [DATA_W-1:0]   wb1_data,
  input  logic [REG_W-1:0]    opa_addr,
  input  logic [REG_W-1:0]    opb_addr,
  output logic                opa_pending,
  output logic [TICKET_W-1:0] opa_ticket,
  output logic                opa_ready,
  output logic [DATA_W-1:0]   opa_data,
  output logic                opb_pending,
  output logic [TICKET_W-1:0] opb_ticket,
  output logic                opb_ready,
  output logic [DATA_W-1:0]   opb_data,
  output logic                commit_valid,
  output logic                commit_we,
  output logic [REG_W-1:0]    commit_dest,
  output logic [DATA_W-1:0]   commit_data,
  output logic [PC_W-1:0]     commit_pc,
  output logic [TICKET_W-1:0] commit_ticket
);

  localparam logic [TICKET_W:0]   FULL_COUNT = (TICKET_W+1)'(ENTRIES);
  localparam logic [TICKET_W:0]   COUNT_ONE  = (TICKET_W+1)'(1);
  localparam logic [TICKET_W-1:0] PTR_ONE    = TICKET_W'(1);

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0]             done;
  logic [ENTRIES-1:0]             we;
  logic [ENTRIES-1:0][REG_W-1:0]  dest;
  logic [ENTRIES-1:0][PC_W-1:0]   pc;
  logic [ENTRIES-1:0][DATA_W-1:0] data;
  logic [TICKET_W-1:0]            head;
  logic [TICKET_W-1:0]            tail;
  logic [TICKET_W:0]              count;

  logic alloc_fire;
  logic wb0_hit;
  logic wb1_hit;

  assign alloc_ready  = (count != FULL_COUNT);
  assign alloc_fire   = alloc_valid & alloc_ready & ~flush;
  assign tail_rob     = tail;

  assign wb0_hit = wb0_valid & valid[wb0_ticket] & ~done[wb0_ticket];
  assign wb1_hit = wb1_valid & valid[wb1_ticket] & ~done[wb1_ticket];

  assign commit_valid  = valid[head] & done[head] & ~flush;
  assign commit_we     = we[head];
  assign commit_dest   = dest[head];
  assign commit_data   = data[head];
  assign commit_pc     = pc[head];
  assign commit_ticket = head;

  // A writeback can only target tail when the buffer is full, which blocks
  // allocation, so the wb and alloc writes below never collide on one entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      done  <= '0;
      we    <= '0;
      dest  <= '0;
      pc    <= '0;
      data  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      valid <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wb0_hit) begin
        done[wb0_ticket] <= 1'b1;
        data[wb0_ticket] <= wb0_data;
      end
      if (wb1_hit) begin
        done[wb1_ticket] <= 1'b1;
        data[wb1_ticket] <= wb1_data;
      end
      if (commit_valid) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_ONE;
      end
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        we[tail]    <= alloc_we;
        dest[tail]  <= alloc_dest;
        pc[tail]    <= alloc_pc;
        data[tail]  <= '0;
        tail        <= tail + PTR_ONE;
      end
      case ({alloc_fire, commit_valid})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  rob_lookup #(
    .ENTRIES (ENTRIES),
    .TICKET_W(TICKET_W),
    .DATA_W  (DATA_W),
    .REG_W   (REG_W)
  ) u_lookup_a (
    .valid  (valid),
    .we     (we),
    .done   (done),
    .dest   (dest),
    .data   (data),
    .tail   (tail),
    .addr   (opa_addr),
    .pending(opa_pending),
    .ticket (opa_ticket),
    .ready  (opa_ready),
    .result (opa_data)
  );

  rob_lookup #(
    .ENTRIES (ENTRIES),
    .TICKET_W(TICKET_W),
    .DATA_W  (DATA_W),
    .REG_W   (REG_W)
  ) u_lookup_b (
    .valid  (valid),
    .we     (we),
    .done   (done),
    .dest   (dest),
    .data   (data),
    .tail   (tail),
    .addr   (opb_addr),
    .pending(opb_pending),
    .ticket (opb_ticket),
    .ready  (opb_ready),
    .result (opb_data)
  );

endmodule

// File: tb/tb_rob_buffer.sv
// Directed bench for rob_buffer: commits are checked by a scoreboard monitor,
// lookups and flow-control outputs by inline checks.
module tb_rob_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        alloc_valid;
  logic [2:0]  alloc_dest;
  logic        alloc_we;
  logic [15:0] alloc_pc;
  logic        alloc_ready;
  logic [2:0]  tail_rob;
  logic        wb0_valid;
  logic [2:0]  wb0_ticket;
  logic [15:0] wb0_data;
  logic        wb1_valid;
  logic [2:0]  wb1_ticket;
  logic [15:0] wb1_data;
  logic [2:0]  opa_addr;
  logic [2:0]  opb_addr;
  logic        opa_pending;
  logic [2:0]  opa_ticket;
  logic        opa_ready;
  logic [15:0] opa_data;
  logic        opb_pending;
  logic [2:0]  opb_ticket;
  logic        opb_ready;
  logic [15:0] opb_data;
  logic        commit_valid;
  logic        commit_we;
  logic [2:0]  commit_dest;
  logic [15:0] commit_data;
  logic [15:0] commit_pc;
  logic [2:0]  commit_ticket;

  rob_buffer #(
    .ENTRIES (8),
    .TICKET_W(3),
    .DATA_W  (16),
    .REG_W   (3),
    .PC_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .alloc_valid  (alloc_valid),
    .alloc_dest   (alloc_dest),
    .alloc_we     (alloc_we),
    .alloc_pc     (alloc_pc),
    .alloc_ready  (alloc_ready),
    .tail_rob     (tail_rob),
    .wb0_valid    (wb0_valid),
    .wb0_ticket   (wb0_ticket),
    .wb0_data     (wb0_data),
    .wb1_valid    (wb1_valid),
    .wb1_ticket   (wb1_ticket),
    .wb1_data     (wb1_data),
    .opa_addr     (opa_addr),
    .opb_addr     (opb_addr),
    .opa_pending  (opa_pending),
    .opa_ticket   (opa_ticket),
    .opa_ready    (opa_ready),
    .opa_data     (opa_data),
    .opb_pending  (opb_pending),
    .opb_ticket   (opb_ticket),
    .opb_ready    (opb_ready),
    .opb_data     (opb_data),
    .commit_valid (commit_valid),
    .commit_we    (commit_we),
    .commit_dest  (commit_dest),
    .commit_data  (commit_data),
    .commit_pc    (commit_pc),
    .commit_ticket(commit_ticket)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ticket;
    logic [15:0] data;
    logic [15:0] pc;
    logic [2:0]  dest;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] t, input logic [15:0] d, input logic [15:0] p,
                      input logic [2:0] r, input logic w);
    exp_t e;
    e.ticket = t; e.data = d; e.pc = p; e.dest = r; e.we = w;
    sb.push_back(e);
  endtask

  // Commit monitor: every retirement must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b0 && commit_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_commit: got ticket %0d data 0x%0h, expected no commit",
                 commit_ticket, commit_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit", {commit_ticket, commit_data, commit_pc, commit_dest, commit_we},
              {e.ticket, e.data, e.pc, e.dest, e.we});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid = 1'b0;
    wb0_valid   = 1'b0;
    wb1_valid   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic do_alloc(input logic [2:0] r, input logic w, input logic [15:0] p,
                          input logic [2:0] exp_ticket);
    check("alloc_ticket", tail_rob, exp_ticket);
    check("alloc_ready_pre", alloc_ready, 1);
    alloc_valid = 1'b1; alloc_dest = r; alloc_we = w; alloc_pc = p;
    cyc();
    alloc_valid = 1'b0;
  endtask

  task automatic set_wb0(input logic [2:0] t, input logic [15:0] d);
    wb0_valid = 1'b1; wb0_ticket = t; wb0_data = d;
  endtask

  task automatic set_wb1(input logic [2:0] t, input logic [15:0] d);
    wb1_valid = 1'b1; wb1_ticket = t; wb1_data = d;
  endtask

  task automatic look(input logic [2:0] a, input logic [2:0] b);
    opa_addr = a; opb_addr = b;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    alloc_dest = '0; alloc_we = 1'b0; alloc_pc = '0;
    wb0_ticket = '0; wb0_data = '0; wb1_ticket = '0; wb1_data = '0;
    opa_addr = '0; opb_addr = '0;
    repeat (2) cyc();
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_tail", tail_rob, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_opa_pending", opa_pending, 0);
    check("rst_opa_data", opa_data, 0);
    reset = 1'b0;
    cyc();

    // 1: asynchronous reset mid-operation
    opa_addr = 3'd1;
    do_alloc(3'd1, 1'b1, 16'h0010, 3'd0);
    do_alloc(3'd1, 1'b1, 16'h0014, 3'd1);
    do_alloc(3'd1, 1'b1, 16'h0018, 3'd2);
    check("t1_pending_before", opa_pending, 1);
    check("t1_ticket_before", opa_ticket, 2);
    check("t1_tail_before", tail_rob, 3);
    reset = 1'b1;
    #1;
    check("t1_alloc_ready", alloc_ready, 1);
    check("t1_tail", tail_rob, 0);
    check("t1_commit_valid", commit_valid, 0);
    check("t1_opa_pending", opa_pending, 0);
    reset = 1'b0;
    #1;

    // 2: out-of-order writeback, in-order commit
    push(3'd0, 16'h0001, 16'h0100, 3'd1, 1'b1);
    push(3'd1, 16'h0002, 16'h0104, 3'd2, 1'b1);
    push(3'd2, 16'h0003, 16'h0108, 3'd3, 1'b1);
    do_alloc(3'd1, 1'b1, 16'h0100, 3'd0);
    do_alloc(3'd2, 1'b1, 16'h0104, 3'd1);
    do_alloc(3'd3, 1'b1, 16'h0108, 3'd2);
    set_wb1(3'd2, 16'h0003); cyc(); clear_inputs();
    check("t2_no_commit_yet", commit_valid, 0);
    set_wb0(3'd0, 16'h0001); cyc(); clear_inputs();
    check("t2_commit0_valid", commit_valid, 1);
    check("t2_commit0_ticket", commit_ticket, 0);
    set_wb1(3'd1, 16'h0002); cyc(); clear_inputs();
    check("t2_commit1_valid", commit_valid, 1);
    check("t2_commit1_ticket", commit_ticket, 1);
    cyc();
    check("t2_commit2_valid", commit_valid, 1);
    check("t2_commit2_ticket", commit_ticket, 2);
    cyc();
    check("t2_drained", commit_valid, 0);
    check("t2_sb_empty", sb.size(), 0);

    // 3: full buffer, ignored alloc, wrap of tail
    do_reset();
    for (int k = 0; k < 8; k++)
      do_alloc(3'(k), 1'b1, 16'h0200 + 16'(k), 3'(k));
    check("t3_full_ready", alloc_ready, 0);
    check("t3_full_tail", tail_rob, 0);
    alloc_valid = 1'b1; alloc_dest = 3'd7; alloc_we = 1'b1; alloc_pc = 16'hFFFF;
    cyc();
    alloc_valid = 1'b0;
    check("t3_ninth_tail", tail_rob, 0);
    check("t3_ninth_ready", alloc_ready, 0);
    look(3'd7, 3'd0);
    check("t3_r7_ticket", opa_ticket, 7);
    check("t3_r0_ticket", opb_ticket, 0);
    push(3'd0, 16'h0010, 16'h0200, 3'd0, 1'b1);
    set_wb0(3'd0, 16'h0010); cyc(); clear_inputs();
    check("t3_commit_valid", commit_valid, 1);
    check("t3_ready_during_commit", alloc_ready, 0);
    cyc();
    check("t3_ready_after_commit", alloc_ready, 1);
    do_alloc(3'd2, 1'b1, 16'h0300, 3'd0);
    check("t3_full_again", alloc_ready, 0);

    // 4: youngest producer lookup
    do_reset();
    look(3'd3, 3'd5);
    do_alloc(3'd3, 1'b1, 16'h0400, 3'd0);
    do_alloc(3'd3, 1'b1, 16'h0404, 3'd1);
    do_alloc(3'd3, 1'b0, 16'h0408, 3'd2);
    check("t4_pending", opa_pending, 1);
    check("t4_ticket", opa_ticket, 1);
    check("t4_ready0", opa_ready, 0);
    check("t4_data0", opa_data, 0);
    set_wb0(3'd1, 16'h0042); cyc(); clear_inputs();
    check("t4_ready1", opa_ready, 1);
    check("t4_data1", opa_data, 16'h0042);
    check("t4_ticket1", opa_ticket, 1);
    check("t4_b_pending", opb_pending, 0);
    check("t4_b_ticket", opb_ticket, 0);
    check("t4_b_data", opb_data, 0);

    // 5: port 1 priority, ignored writebacks
    do_reset();
    push(3'd0, 16'h00BB, 16'h0500, 3'd4, 1'b1);
    do_alloc(3'd4, 1'b1, 16'h0500, 3'd0);
    set_wb0(3'd0, 16'h00AA); set_wb1(3'd0, 16'h00BB); cyc(); clear_inputs();
    check("t5_commit_data", commit_data, 16'h00BB);
    cyc();
    set_wb0(3'd5, 16'h0077); cyc(); clear_inputs();
    check("t5_no_commit", commit_valid, 0);
    for (int k = 1; k <= 5; k++)
      do_alloc(3'(k), 1'b1, 16'h0500 + 16'(k), 3'(k));
    look(3'd5, 3'd3);
    check("t5_stale_pending", opa_pending, 1);
    check("t5_stale_ticket", opa_ticket, 5);
    check("t5_stale_ready", opa_ready, 0);
    set_wb0(3'd3, 16'h0033); cyc(); clear_inputs();
    set_wb1(3'd3, 16'h0099); cyc(); clear_inputs();
    look(3'd5, 3'd3);
    check("t5_done_ready", opb_ready, 1);
    check("t5_done_data", opb_data, 16'h0033);
    set_wb0(3'd6, 16'h0066);
    do_alloc(3'd6, 1'b1, 16'h0506, 3'd6);
    clear_inputs();
    look(3'd6, 3'd3);
    check("t5_alloc_wb_pending", opa_pending, 1);
    check("t5_alloc_wb_ticket", opa_ticket, 6);
    check("t5_alloc_wb_ready", opa_ready, 0);

    // 6: flush squashes pending commit and same-cycle alloc
    do_reset();
    for (int k = 0; k < 4; k++)
      do_alloc(3'(k + 1), 1'b1, 16'h0600 + 16'(k), 3'(k));
    set_wb0(3'd3, 16'h0004); set_wb1(3'd2, 16'h0003); cyc(); clear_inputs();
    set_wb0(3'd1, 16'h0002); cyc(); clear_inputs();
    set_wb0(3'd0, 16'h0001); cyc(); clear_inputs();
    check("t6_commit_ready", commit_valid, 1);
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_dest = 3'd7; alloc_we = 1'b1; alloc_pc = 16'h0700;
    #1;
    check("t6_flush_commit", commit_valid, 0);
    cyc();
    clear_inputs();
    check("t6_ready", alloc_ready, 1);
    check("t6_tail", tail_rob, 0);
    check("t6_commit_after", commit_valid, 0);
    look(3'd1, 3'd7);
    check("t6_a_pending", opa_pending, 0);
    check("t6_b_pending", opb_pending, 0);
    repeat (3) cyc();
    check("t6_quiet", commit_valid, 0);

    check("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
